// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared BCD widths, digit limits and field-select encoding for the stopwatch timekeeper
package stopwatch_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] SEC_MAX_TENS = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;
  typedef enum logic {SEL_MIN = 1'b0, SEL_SEC = 1'b1} sel_e;
endpackage

// File: rtl/stopwatch_timekeeper_if.sv
// stopwatch_timekeeper_if: tick/button/mode inputs and BCD digit/pause/blank outputs; master drives inputs, slave is the timekeeper
interface stopwatch_timekeeper_if;
  import stopwatch_pkg::*;
  logic tick_1hz, tick_adj, tick_blink, btn_pause, adj, sel;
  logic [BCD_W-1:0] min_tens, min_ones, sec_tens, sec_ones;
  logic paused, blank_min, blank_sec;
  modport master (
    output tick_1hz, tick_adj, tick_blink, btn_pause, adj, sel,
    input  min_tens, min_ones, sec_tens, sec_ones, paused, blank_min, blank_sec
  );
  modport slave (
    input  tick_1hz, tick_adj, tick_blink, btn_pause, adj, sel,
    output min_tens, min_ones, sec_tens, sec_ones, paused, blank_min, blank_sec
  );
endinterface

// File: rtl/stopwatch_timekeeper_bcd2_counter.sv
// bcd2_counter: two-digit BCD counter (clk, rst, inc in; tens, ones, carry out) wrapping to 00 after MAX_TENS:MAX_ONES or any illegal value
module bcd2_counter
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX_TENS = 4'd5,
  parameter logic [BCD_W-1:0] MAX_ONES = 4'd9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             carry
);
  logic w_wrap, w_ones_roll;
  always_comb begin
    w_wrap = tens > MAX_TENS || (tens == MAX_TENS && ones >= MAX_ONES);
    w_ones_roll = ones >= DIGIT_MAX;
    carry = w_wrap & inc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      tens <= w_wrap ? '0 : w_ones_roll ? tens + 1'b1 : tens;
      ones <= (w_wrap | w_ones_roll) ? '0 : ones + 1'b1;
    end
  end
endmodule

// File: rtl/stopwatch_timekeeper.sv
// stopwatch_timekeeper: MM:SS BCD stopwatch (clk, rst, bus slave: ticks/pause/adj/sel in, digits/paused/blank out) with pause toggle, adjust and blink
module stopwatch_timekeeper
  import stopwatch_pkg::*;
#(
  parameter int MM_MAX = 59
) (
  input logic                  clk,
  input logic                  rst,
  stopwatch_timekeeper_if.slave bus
);
  logic r_btn_prev, r_paused, r_blink_phase, r_blank_min, r_blank_sec;
  logic w_sec_inc, w_min_inc, w_sec_carry, w_sel_min, w_sel_sec;
  always_comb begin
    w_sel_min = sel_e'(bus.sel) == SEL_MIN;
    w_sel_sec = sel_e'(bus.sel) == SEL_SEC;
    w_sec_inc = bus.adj ? bus.tick_adj & w_sel_sec : bus.tick_1hz & ~r_paused;
    w_min_inc = bus.adj ? bus.tick_adj & w_sel_min : w_sec_carry;
  end
  bcd2_counter #(.MAX_TENS(SEC_MAX_TENS), .MAX_ONES(DIGIT_MAX)) u_sec (
    .clk(clk), .rst(rst), .inc(w_sec_inc),
    .tens(bus.sec_tens), .ones(bus.sec_ones), .carry(w_sec_carry)
  );
  bcd2_counter #(.MAX_TENS(BCD_W'(MM_MAX / 10)), .MAX_ONES(BCD_W'(MM_MAX % 10))) u_min (
    .clk(clk), .rst(rst), .inc(w_min_inc),
    .tens(bus.min_tens), .ones(bus.min_ones), .carry()
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_prev <= 1'b1;
      r_paused <= 1'b0;
      r_blink_phase <= 1'b0;
      r_blank_min <= 1'b0;
      r_blank_sec <= 1'b0;
    end else begin
      r_btn_prev <= bus.btn_pause;
      r_paused <= r_paused ^ (bus.btn_pause & ~r_btn_prev);
      r_blink_phase <= bus.adj & (r_blink_phase ^ bus.tick_blink);
      r_blank_min <= bus.adj & w_sel_min & r_blink_phase;
      r_blank_sec <= bus.adj & w_sel_sec & r_blink_phase;
    end
  end
  assign bus.paused = r_paused;
  assign bus.blank_min = r_blank_min;
  assign bus.blank_sec = r_blank_sec;
endmodule
